// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with stall/bubble/flush control and EX scratch feedback.
// Optional bubble/hold performance counters under EX_MEM_PERF_EN.
module ex_mem_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REGADDR_W = 5,
  parameter int unsigned ALUOP_W   = 8,
  parameter logic [ALUOP_W-1:0] NOP_OP = '0,
  parameter int unsigned CARRY_W   = 64,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 3,
  parameter int unsigned PERF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic                 ex_wreg,
  input  logic                 ex_whilo,
  input  logic [REGADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic [DATA_W-1:0]    ex_mem_addr,
  input  logic [DATA_W-1:0]    ex_reg2,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [CARRY_W-1:0]   carry_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic                 mem_valid,
  output logic [REGADDR_W-1:0] mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic                 mem_whilo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [DATA_W-1:0]    mem_mem_addr,
  output logic [DATA_W-1:0]    mem_reg2,
  output logic [CARRY_W-1:0]   carry_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [1:0]           stage_act
`ifdef EX_MEM_PERF_EN
  ,
  output logic [PERF_W-1:0]    bubble_cnt,
  output logic [PERF_W-1:0]    hold_cnt
`endif
);

  typedef struct packed {
    logic                 valid;
    logic                 wreg;
    logic                 whilo;
    logic [REGADDR_W-1:0] wd;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    logic [DATA_W-1:0]    addr;
    logic [DATA_W-1:0]    reg2;
    logic [ALUOP_W-1:0]   aluop;
  } bundle_t;

  typedef enum logic [1:0] {
    ACT_ADV   = 2'd0,
    ACT_BUB   = 2'd1,
    ACT_HOLD  = 2'd2,
    ACT_FLUSH = 2'd3
  } act_e;

  localparam bundle_t NOP_B = '{
    valid: 1'b0,
    wreg:  1'b0,
    whilo: 1'b0,
    wd:    '0,
    wdata: '0,
    hi:    '0,
    lo:    '0,
    addr:  '0,
    reg2:  '0,
    aluop: NOP_OP
  };

  bundle_t            r_b;
  bundle_t            w_b_nxt;
  bundle_t            w_ex;
  logic [CARRY_W-1:0] r_carry;
  logic [CARRY_W-1:0] w_carry_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  act_e               r_act;
  act_e               w_act;
  logic [1:0]         w_sn;
  logic               w_s;
  logic               w_n;

  // Own bit and next-stage bit, taken by shift so the full vector is consumed.
  assign w_sn = 2'(stall >> STAGE_IDX);
  assign w_s  = w_sn[0];
  assign w_n  = w_sn[1];

  always_comb begin
    w_ex       = NOP_B;
    w_ex.valid = ex_valid;
    w_ex.wreg  = ex_wreg;
    w_ex.whilo = ex_whilo;
    w_ex.wd    = ex_wd;
    w_ex.wdata = ex_wdata;
    w_ex.hi    = ex_hi;
    w_ex.lo    = ex_lo;
    w_ex.addr  = ex_mem_addr;
    w_ex.reg2  = ex_reg2;
    w_ex.aluop = ex_aluop;
  end

  // Flush outranks stall; s=0 with n=1 falls through to advance.
  always_comb begin
    w_act = ACT_ADV;
    priority case (1'b1)
      flush:        w_act = ACT_FLUSH;
      w_s && !w_n:  w_act = ACT_BUB;
      w_s && w_n:   w_act = ACT_HOLD;
      default:      w_act = ACT_ADV;
    endcase
  end

  always_comb begin
    w_b_nxt     = r_b;
    w_carry_nxt = '0;
    w_cnt_nxt   = '0;
    unique case (w_act)
      ACT_FLUSH: w_b_nxt = NOP_B;
      ACT_BUB: begin
        w_b_nxt     = NOP_B;
        w_carry_nxt = carry_i;
        w_cnt_nxt   = cnt_i;
      end
      ACT_HOLD: begin
        w_carry_nxt = carry_i;
        w_cnt_nxt   = cnt_i;
      end
      default: w_b_nxt = w_ex;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_b     <= NOP_B;
      r_carry <= '0;
      r_cnt   <= '0;
      r_act   <= ACT_ADV;
    end else begin
      r_b     <= w_b_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_act   <= w_act;
    end
  end

  assign mem_valid    = r_b.valid;
  assign mem_wd       = r_b.wd;
  assign mem_wreg     = r_b.wreg;
  assign mem_wdata    = r_b.wdata;
  assign mem_hi       = r_b.hi;
  assign mem_lo       = r_b.lo;
  assign mem_whilo    = r_b.whilo;
  assign mem_aluop    = r_b.aluop;
  assign mem_mem_addr = r_b.addr;
  assign mem_reg2     = r_b.reg2;
  assign carry_o      = r_carry;
  assign cnt_o        = r_cnt;
  assign stage_act    = r_act;

`ifdef EX_MEM_PERF_EN
  logic [PERF_W-1:0] r_bub_cnt;
  logic [PERF_W-1:0] r_hold_cnt;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bub_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (w_act == ACT_BUB && !(&r_bub_cnt))
        r_bub_cnt <= r_bub_cnt + 1'b1;
      if (w_act == ACT_HOLD && !(&r_hold_cnt))
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bub_cnt;
  assign hold_cnt   = r_hold_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, advance, bubble, hold, flush,
// illegal stall pattern, async reset and (with EX_MEM_PERF_EN) counter saturation.
module tb_ex_mem_stage;

  localparam int PW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid, ex_wreg, ex_whilo;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] carry_i;
  logic [1:0]  cnt_i;
  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] carry_o;
  logic [1:0]  cnt_o;
  logic [1:0]  stage_act;
`ifdef EX_MEM_PERF_EN
  logic [PW-1:0] bubble_cnt, hold_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  ex_mem_stage #(.PERF_W(PW)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_whilo(ex_whilo),
    .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_aluop(ex_aluop),
    .carry_i(carry_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .carry_o(carry_o), .cnt_o(cnt_o), .stage_act(stage_act)
`ifdef EX_MEM_PERF_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ex(input logic [4:0] wd, input logic [31:0] d,
                         input logic [7:0] op);
    ex_valid    = 1'b1;
    ex_wreg     = 1'b1;
    ex_whilo    = 1'b1;
    ex_wd       = wd;
    ex_wdata    = d;
    ex_hi       = d ^ 32'hFFFF_0000;
    ex_lo       = d ^ 32'h0000_FFFF;
    ex_mem_addr = d + 32'd4;
    ex_reg2     = ~d;
    ex_aluop    = op;
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0;
    load_ex(5'd9, 32'hAAAA_5555, 8'h33);
    carry_i = 64'h1; cnt_i = 2'd1;
    tick(); tick();
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_aluop", 64'(mem_aluop), 64'd0);
    chk("rst_act",   64'(stage_act), 64'd0);
    chk("rst_carry", carry_o, 64'd0);
    rst = 1'b1;

    // advance
    load_ex(5'd5, 32'h1234_5678, 8'h21);
    carry_i = 64'h55; cnt_i = 2'd3;
    tick();
    chk("adv_wd",    64'(mem_wd), 64'd5);
    chk("adv_wreg",  64'(mem_wreg), 64'd1);
    chk("adv_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("adv_valid", 64'(mem_valid), 64'd1);
    chk("adv_hi",    64'(mem_hi), 64'hEDCB_5678);
    chk("adv_addr",  64'(mem_mem_addr), 64'h1234_567C);
    chk("adv_reg2",  64'(mem_reg2), 64'hEDCB_A987);
    chk("adv_op",    64'(mem_aluop), 64'h21);
    chk("adv_carry", carry_o, 64'd0);
    chk("adv_cnt",   64'(cnt_o), 64'd0);
    chk("adv_act",   64'(stage_act), 64'd0);

    // bubble
    stall = 6'b001111;
    carry_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd2;
    tick();
    chk("bub_wreg",  64'(mem_wreg), 64'd0);
    chk("bub_whilo", 64'(mem_whilo), 64'd0);
    chk("bub_valid", 64'(mem_valid), 64'd0);
    chk("bub_wdata", 64'(mem_wdata), 64'd0);
    chk("bub_op",    64'(mem_aluop), 64'd0);
    chk("bub_carry", carry_o, 64'hDEAD_BEEF_0000_0001);
    chk("bub_cnt",   64'(cnt_o), 64'd2);
    chk("bub_act",   64'(stage_act), 64'd1);
`ifdef EX_MEM_PERF_EN
    chk("bub_pc", 64'(bubble_cnt), 64'd1);
`endif

    // load then hold three edges with changing inputs
    stall = '0;
    load_ex(5'd7, 32'hCAFE_0001, 8'h44);
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      load_ex(5'(i + 10), 32'h1000 + 32'(i), 8'(i + 1));
      carry_i = 64'h100 + 64'(i);
      cnt_i   = 2'(i);
      tick();
      chk("hold_wd",    64'(mem_wd), 64'd7);
      chk("hold_wdata", 64'(mem_wdata), 64'hCAFE_0001);
      chk("hold_op",    64'(mem_aluop), 64'h44);
      chk("hold_carry", carry_o, 64'h100 + 64'(i));
      chk("hold_cnt",   64'(cnt_o), 64'(i));
      chk("hold_act",   64'(stage_act), 64'd2);
    end
`ifdef EX_MEM_PERF_EN
    chk("hold_pc", 64'(hold_cnt), 64'd3);
`endif

    // flush over a hold request
    flush = 1'b1;
    carry_i = 64'h77; cnt_i = 2'd3;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(mem_valid), 64'd0);
    chk("fl_wreg",  64'(mem_wreg), 64'd0);
    chk("fl_wdata", 64'(mem_wdata), 64'd0);
    chk("fl_carry", carry_o, 64'd0);
    chk("fl_cnt",   64'(cnt_o), 64'd0);
    chk("fl_act",   64'(stage_act), 64'd3);
`ifdef EX_MEM_PERF_EN
    chk("fl_hpc", 64'(hold_cnt), 64'd3);
    chk("fl_bpc", 64'(bubble_cnt), 64'd1);
`endif

    // s=0, n=1 behaves as advance
    stall = 6'b010000;
    load_ex(5'd3, 32'h0BAD_F00D, 8'h12);
    tick();
    chk("ill_wdata", 64'(mem_wdata), 64'h0BAD_F00D);
    chk("ill_act",   64'(stage_act), 64'd0);
    chk("ill_carry", carry_o, 64'd0);

    // hold to load scratch, then async reset mid-cycle
    stall = 6'b011111;
    carry_i = 64'h99; cnt_i = 2'd1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wdata", 64'(mem_wdata), 64'd0);
    chk("arst_wreg",  64'(mem_wreg), 64'd0);
    chk("arst_carry", carry_o, 64'd0);
    chk("arst_cnt",   64'(cnt_o), 64'd0);
    chk("arst_act",   64'(stage_act), 64'd0);
`ifdef EX_MEM_PERF_EN
    chk("arst_pc", 64'(hold_cnt), 64'd0);
`endif
    tick();
    rst = 1'b1;

`ifdef EX_MEM_PERF_EN
    stall = 6'b001111;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_bpc", 64'(bubble_cnt), 64'd15);
    chk("sat_hpc", 64'(hold_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX→MEM pipeline stage register between the execute and memory-access stages of the MIPS core. Captures the execute result bundle each cycle, inserts bubbles or holds under the global stall vector, and kills its contents on a pipeline flush. Carries multi-cycle execute scratch state (HI/LO accumulator, cycle counter) back to EX while the stage is stalled. Adds a valid bit, a last-action status code and optional stall/bubble performance counters.

## Interface
- DATA_W, 32, width of data, HI, LO, memory-address and reg2 fields
- REGADDR_W, 5, destination register address width
- ALUOP_W, 8, ALU opcode width
- NOP_OP, 0, ALU opcode loaded on reset, bubble and flush
- CARRY_W, 64, multi-cycle scratch width (HI:LO accumulator)
- CNT_W, 2, multi-cycle step counter width
- STALL_W, 6, stall vector width
- STAGE_IDX, 3, stall bit owned by this stage; STAGE_IDX+1 < STALL_W
- PERF_W, 16, performance counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  STALL_W  global stall vector, 1 = stop
- flush  in  1  kill stage contents (exception / redirect)
- ex_valid, ex_wreg, ex_whilo  in  1 each  valid, GPR write enable, HI/LO write enable
- ex_wd  in  REGADDR_W  destination register
- ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2  in  DATA_W each  result bundle
- ex_aluop  in  ALUOP_W  opcode
- carry_i  in  CARRY_W;  cnt_i  in  CNT_W  scratch state from EX
- mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as inputs  registered bundle to MEM
- carry_o  out  CARRY_W;  cnt_o  out  CNT_W  scratch state back to EX
- stage_act  out  2  last action: 0 ADVANCE, 1 BUBBLE, 2 HOLD, 3 FLUSH
- bubble_cnt, hold_cnt  out  PERF_W each  present only with perf macro

## Operation
- Let s = stall[STAGE_IDX], n = stall[STAGE_IDX+1]. Per rising edge, first match wins:
- FLUSH (flush=1): bundle cleared (valid, wreg, whilo = 0; data fields 0; wd 0; aluop NOP_OP); carry_o, cnt_o ← 0; stage_act ← 3. Overrides any stall.
- BUBBLE (s=1, n=0): bundle cleared as FLUSH; carry_o ← carry_i, cnt_o ← cnt_i; stage_act ← 1.
- ADVANCE (s=0): all mem_* ← ex_*; carry_o, cnt_o ← 0; stage_act ← 0.
- HOLD (s=1, n=1): mem_* unchanged; carry_o ← carry_i, cnt_o ← cnt_i; stage_act ← 2.
- s=0 with n=1 is illegal from the stall controller; treated as ADVANCE.
- A cleared bundle always has mem_wreg=0 and mem_whilo=0, so no architectural write escapes.

## Timing
- Reset (rst low, asynchronous): every output 0, mem_aluop = NOP_OP, stage_act = 0; counters 0. Release is synchronous to next clk edge; first post-reset edge follows normal rules.
- Latency: exactly one cycle ex_* → mem_*; no combinational input→output path.
- carry_o/cnt_o valid one cycle after a stalled edge; EX reads them next cycle to continue a multi-cycle op (MADD/MSUB, DIV).
- Reset mid multi-cycle op: scratch state lost; EX restarts from cnt 0.
- Flush during multi-cycle op: scratch cleared same edge as bundle.

## Configuration
- EX_MEM_PERF_EN defined: bubble_cnt increments on every BUBBLE edge, hold_cnt on every HOLD edge; both saturate at 2^PERF_W−1; FLUSH/ADVANCE leave them unchanged; cleared only by reset.
- Undefined: counters and their ports absent; all other behaviour identical.

## Test plan
- Reset: rst=0 mid-cycle with bundle loaded -> all outputs 0 immediately, mem_aluop=NOP_OP, stage_act=0.
- Advance: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678, ex_valid=1 -> next edge mem_wd=5, mem_wreg=1, mem_wdata=0x1234_5678, carry_o=0, stage_act=0.
- Bubble: stall=6'b001111, carry_i=0xDEAD_BEEF_0000_0001, cnt_i=2 -> mem_wreg=0, mem_valid=0, mem_aluop=NOP_OP, carry_o=0xDEAD_BEEF_0000_0001, cnt_o=2, stage_act=1; bubble_cnt +1 with macro.
- Hold: load bundle, then stall=6'b011111 for 3 edges with changing ex_* -> mem_* unchanged, carry_o tracks carry_i, stage_act=2; hold_cnt=3 with macro.
- Flush over stall: flush=1, stall=6'b011111, loaded bundle -> mem_valid=0, mem_wreg=0, carry_o=0, cnt_o=0, stage_act=3.
- Saturation (macro, PERF_W=4): 20 consecutive BUBBLE edges -> bubble_cnt=15.
